// File: rtl/snoop_bus_ctrl_if.sv
// Bus bundle between snoop_bus_ctrl (master) and its cache controllers (slave):
// requests, snoop broadcast/replies, responses and optional statistics.
interface snoop_bus_ctrl_if #(
  parameter int unsigned NPROC  = 3,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 3
);
  logic [NPROC-1:0]        req;
  logic [2*NPROC-1:0]      req_cmd;
  logic [ADDR_W*NPROC-1:0] req_addr;
  logic [DATA_W*NPROC-1:0] req_data;
  logic [NPROC-1:0]        gnt;
  logic                    bus_valid;
  logic [1:0]              bus_cmd;
  logic [ADDR_W-1:0]       bus_addr;
  logic [NPROC-1:0]        bus_src;
  logic [NPROC-1:0]        snoop_shared;
  logic [NPROC-1:0]        snoop_dirty;
  logic [DATA_W*NPROC-1:0] snoop_wb_data;
  logic                    resp_valid;
  logic [DATA_W-1:0]       resp_data;
  logic                    resp_shared;
  logic                    err;
  logic                    busy;
  logic [15:0]             stat_txn;
  logic [15:0]             stat_interv;

  modport master (
    input  req, req_cmd, req_addr, req_data, snoop_shared, snoop_dirty, snoop_wb_data,
    output gnt, bus_valid, bus_cmd, bus_addr, bus_src, resp_valid, resp_data, resp_shared,
           err, busy, stat_txn, stat_interv
  );

  modport slave (
    output req, req_cmd, req_addr, req_data, snoop_shared, snoop_dirty, snoop_wb_data,
    input  gnt, bus_valid, bus_cmd, bus_addr, bus_src, resp_valid, resp_data, resp_shared,
           err, busy, stat_txn, stat_interv
  );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// Round-robin snooping bus controller owning the shared data memory.
// Define SNOOP_STATS_EN to enable the saturating stat_txn/stat_interv counters.
module snoop_bus_ctrl #(
  parameter int unsigned NPROC      = 3,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned SNOOP_WAIT = 1
) (
  input logic              clock,
  input logic              clear,
  snoop_bus_ctrl_if.master bus
);
  localparam int unsigned PtrW  = $clog2(NPROC);
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {StIdle, StBcast, StWait, StEval, StResp} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NPROC-1:0]    shared_m_q, shared_m_d;
  logic [NPROC-1:0]    dirty_m_q, dirty_m_d;
  logic [DATA_W-1:0]   wb_q, wb_d;
  logic [NPROC-1:0]    gnt_q, gnt_d;
  logic                bus_valid_q, bus_valid_d;
  logic [1:0]          bus_cmd_q, bus_cmd_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [NPROC-1:0]    bus_src_q, bus_src_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_shared_q, resp_shared_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   mem_q [Depth];
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic                winner_found;
  logic [PtrW-1:0]     winner, idx;
  logic [NPROC-1:0]    dirty_now;
  logic [DATA_W-1:0]   wb_sel;

  // First requester strictly after the pointer, wrapping; the pointer itself is last.
  always_comb begin
    winner_found = 1'b0;
    winner       = '0;
    idx          = '0;
    for (int k = 1; k <= int'(NPROC); k++) begin
      idx = PtrW'((int'(ptr_q) + k) % int'(NPROC));
      if (!winner_found && bus.req[idx]) begin
        winner_found = 1'b1;
        winner       = idx;
      end
    end
  end

  // The originator never intervenes on its own transaction.
  always_comb begin
    dirty_now = bus.snoop_dirty & ~gnt_q;
    wb_sel    = '0;
    for (int i = int'(NPROC) - 1; i >= 0; i--) begin
      if (dirty_now[i]) wb_sel = bus.snoop_wb_data[i*int'(DATA_W) +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    shared_m_d    = shared_m_q;
    dirty_m_d     = dirty_m_q;
    wb_d          = wb_q;
    gnt_d         = gnt_q;
    bus_valid_d   = 1'b0;
    bus_cmd_d     = bus_cmd_q;
    bus_addr_d    = bus_addr_q;
    bus_src_d     = bus_src_q;
    resp_valid_d  = 1'b0;
    resp_data_d   = resp_data_q;
    resp_shared_d = resp_shared_q;
    err_d         = err_q;
    mem_we        = 1'b0;
    mem_wdata     = data_q;
    unique case (state_q)
      StIdle: begin
        if (winner_found) begin
          gnt_d       = NPROC'(1) << winner;
          bus_src_d   = NPROC'(1) << winner;
          ptr_d       = winner;
          bus_cmd_d   = bus.req_cmd[int'(winner)*2 +: 2];
          bus_addr_d  = bus.req_addr[int'(winner)*int'(ADDR_W) +: ADDR_W];
          data_d      = bus.req_data[int'(winner)*int'(DATA_W) +: DATA_W];
          bus_valid_d = 1'b1;
          state_d     = StBcast;
        end
      end
      StBcast: begin
        cnt_d   = 4'(SNOOP_WAIT);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          shared_m_d = bus.snoop_shared & ~gnt_q;
          dirty_m_d  = dirty_now;
          wb_d       = wb_sel;
          state_d    = StEval;
        end
      end
      StEval: begin
        if (bus_cmd_q == 2'b00) begin
          mem_we      = 1'b1;
          mem_wdata   = data_q;
          resp_data_d = data_q;
        end else if (|dirty_m_q) begin
          mem_we      = 1'b1;
          mem_wdata   = wb_q;
          resp_data_d = wb_q;
        end else if (bus_cmd_q == 2'b11) begin
          resp_data_d = '0;
        end else begin
          resp_data_d = mem_q[bus_addr_q];
        end
        resp_shared_d = bus_cmd_q[1] ? 1'b0 : |shared_m_q;
        // More than one modified copy is a coherence violation.
        if ((dirty_m_q & (dirty_m_q - NPROC'(1))) != '0) err_d = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= StIdle;
      ptr_q         <= PtrW'(NPROC - 1);
      cnt_q         <= '0;
      data_q        <= '0;
      shared_m_q    <= '0;
      dirty_m_q     <= '0;
      wb_q          <= '0;
      gnt_q         <= '0;
      bus_valid_q   <= 1'b0;
      bus_cmd_q     <= '0;
      bus_addr_q    <= '0;
      bus_src_q     <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_shared_q <= 1'b0;
      err_q         <= 1'b0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      shared_m_q    <= shared_m_d;
      dirty_m_q     <= dirty_m_d;
      wb_q          <= wb_d;
      gnt_q         <= gnt_d;
      bus_valid_q   <= bus_valid_d;
      bus_cmd_q     <= bus_cmd_d;
      bus_addr_q    <= bus_addr_d;
      bus_src_q     <= bus_src_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      resp_shared_q <= resp_shared_d;
      err_q         <= err_d;
      if (mem_we) mem_q[bus_addr_q] <= mem_wdata;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.bus_valid   = bus_valid_q;
  assign bus.bus_cmd     = bus_cmd_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_src     = bus_src_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_shared = resp_shared_q;
  assign bus.err         = err_q;
  assign bus.busy        = (state_q != StIdle);

`ifdef SNOOP_STATS_EN
  logic [15:0] stat_txn_q, stat_txn_d;
  logic [15:0] stat_interv_q, stat_interv_d;

  always_comb begin
    stat_txn_d    = stat_txn_q;
    stat_interv_d = stat_interv_q;
    if (state_q == StResp && stat_txn_q != 16'hFFFF) stat_txn_d = stat_txn_q + 16'd1;
    if (state_q == StEval && |dirty_m_q && stat_interv_q != 16'hFFFF) begin
      stat_interv_d = stat_interv_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      stat_txn_q    <= '0;
      stat_interv_q <= '0;
    end else begin
      stat_txn_q    <= stat_txn_d;
      stat_interv_q <= stat_interv_d;
    end
  end

  assign bus.stat_txn    = stat_txn_q;
  assign bus.stat_interv = stat_interv_q;
`else
  assign bus.stat_txn    = '0;
  assign bus.stat_interv = '0;
`endif
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Self-checking bench for snoop_bus_ctrl: directed scenarios plus randomized transactions
// compared against a transaction-level reference model.
module tb_snoop_bus_ctrl;
  localparam int NPROC      = 3;
  localparam int ADDR_W     = 3;
  localparam int DATA_W     = 3;
  localparam int SNOOP_WAIT = 1;

  logic clock = 1'b0;
  logic clear;
  always #5 clock = ~clock;

  snoop_bus_ctrl_if #(.NPROC(NPROC), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  snoop_bus_ctrl #(
    .NPROC(NPROC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SNOOP_WAIT(SNOOP_WAIT)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus_if)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [2**ADDR_W];
  int                m_ptr;
  bit                m_err;
  int                m_txn;
  int                m_interv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**ADDR_W; i++) m_mem[i] = '0;
    m_ptr    = NPROC - 1;
    m_err    = 1'b0;
    m_txn    = 0;
    m_interv = 0;
  endtask

  task automatic clear_inputs();
    bus_if.req           = '0;
    bus_if.req_cmd       = '0;
    bus_if.req_addr      = '0;
    bus_if.req_data      = '0;
    bus_if.snoop_shared  = '0;
    bus_if.snoop_dirty   = '0;
    bus_if.snoop_wb_data = '0;
  endtask

  task automatic check_stats(input string tag);
`ifdef SNOOP_STATS_EN
    check({tag, "_stat_txn"}, bus_if.stat_txn, m_txn);
    check({tag, "_stat_interv"}, bus_if.stat_interv, m_interv);
`else
    check({tag, "_stat_txn"}, bus_if.stat_txn, 0);
    check({tag, "_stat_interv"}, bus_if.stat_interv, 0);
`endif
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  // keep: requesters still holding req after the grant (winner always drops in RESP).
  task automatic run_txn(input logic [NPROC-1:0] mask, input logic [NPROC-1:0] keep,
                         input logic [1:0] cmd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [NPROC-1:0] sh,
                         input logic [NPROC-1:0] dt, input logic [DATA_W*NPROC-1:0] wb);
    int                w;
    int                first_dirty;
    int                n_dirty;
    logic [NPROC-1:0]  w_oh;
    logic [NPROC-1:0]  sh_m;
    logic [NPROC-1:0]  dt_m;
    logic [DATA_W-1:0] exp_d;
    bit                exp_s;

    w = 0;
    for (int k = NPROC; k >= 1; k--) if (mask[(m_ptr + k) % NPROC]) w = (m_ptr + k) % NPROC;
    w_oh    = '0;
    w_oh[w] = 1'b1;
    sh_m    = sh & ~w_oh;
    dt_m    = dt & ~w_oh;
    first_dirty = -1;
    n_dirty     = 0;
    for (int i = 0; i < NPROC; i++) begin
      if (dt_m[i]) begin
        n_dirty++;
        if (first_dirty < 0) first_dirty = i;
      end
    end
    if (cmd == 2'b00) begin
      exp_d    = d;
      m_mem[a] = d;
    end else if (first_dirty >= 0) begin
      exp_d    = wb[first_dirty*DATA_W +: DATA_W];
      m_mem[a] = exp_d;
    end else if (cmd == 2'b11) begin
      exp_d = '0;
    end else begin
      exp_d = m_mem[a];
    end
    exp_s = (cmd[1] == 1'b0) && (sh_m != '0);
    if (n_dirty > 1) m_err = 1'b1;
    if (first_dirty >= 0 && m_interv < 65535) m_interv++;
    if (m_txn < 65535) m_txn++;
    m_ptr = w;

    check("busy_idle", bus_if.busy, 0);
    bus_if.req      = mask;
    bus_if.req_cmd  = (2*NPROC)'($urandom);
    bus_if.req_addr = (ADDR_W*NPROC)'($urandom);
    bus_if.req_data = (DATA_W*NPROC)'($urandom);
    bus_if.req_cmd[2*w +: 2]           = cmd;
    bus_if.req_addr[w*ADDR_W +: ADDR_W] = a;
    bus_if.req_data[w*DATA_W +: DATA_W] = d;
    @(negedge clock);
    check("gnt", bus_if.gnt, w_oh);
    check("bus_valid", bus_if.bus_valid, 1);
    check("bus_cmd", bus_if.bus_cmd, cmd);
    check("bus_addr", bus_if.bus_addr, a);
    check("bus_src", bus_if.bus_src, w_oh);
    check("busy", bus_if.busy, 1);
    @(negedge clock);
    check("bus_valid_off", bus_if.bus_valid, 0);
    bus_if.req           = mask & keep;
    bus_if.snoop_shared  = sh;
    bus_if.snoop_dirty   = dt;
    bus_if.snoop_wb_data = wb;
    repeat (SNOOP_WAIT) @(negedge clock);
    check("resp_early", bus_if.resp_valid, 0);
    // Replies after the sample point must be ignored.
    bus_if.snoop_shared  = NPROC'($urandom);
    bus_if.snoop_dirty   = NPROC'($urandom);
    bus_if.snoop_wb_data = (DATA_W*NPROC)'($urandom);
    @(negedge clock);
    check("resp_valid", bus_if.resp_valid, 1);
    check("resp_data", bus_if.resp_data, exp_d);
    check("resp_shared", bus_if.resp_shared, exp_s);
    check("err", bus_if.err, m_err);
    check("gnt_resp", bus_if.gnt, w_oh);
    bus_if.req = mask & keep & ~w_oh;
    @(negedge clock);
    check("resp_valid_off", bus_if.resp_valid, 0);
    check("gnt_off", bus_if.gnt, 0);
    check("resp_data_hold", bus_if.resp_data, exp_d);
    check("bus_src_hold", bus_if.bus_src, w_oh);
    check_stats("txn");
  endtask

  initial begin
    logic [NPROC-1:0] dt;
    clear_inputs();
    clear = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_gnt", bus_if.gnt, 0);
    check("rst_bus_valid", bus_if.bus_valid, 0);
    check("rst_bus_cmd", bus_if.bus_cmd, 0);
    check("rst_bus_addr", bus_if.bus_addr, 0);
    check("rst_bus_src", bus_if.bus_src, 0);
    check("rst_resp_valid", bus_if.resp_valid, 0);
    check("rst_resp_data", bus_if.resp_data, 0);
    check("rst_resp_shared", bus_if.resp_shared, 0);
    check("rst_err", bus_if.err, 0);
    check("rst_busy", bus_if.busy, 0);
    check_stats("rst");
    clear = 1'b1;
    @(negedge clock);

    // Write-back then read of the same block
    run_txn(3'b001, 3'b000, 2'b00, 3'd1, 3'b010, 3'b000, 3'b000, '0);
    run_txn(3'b010, 3'b000, 2'b01, 3'd1, 3'b000, 3'b000, 3'b000, '0);
    // Shared read of untouched block
    run_txn(3'b010, 3'b000, 2'b01, 3'd5, 3'b000, 3'b101, 3'b000, '0);
    // Intervention by P2, then memory holds the written-back data
    run_txn(3'b010, 3'b000, 2'b01, 3'd0, 3'b000, 3'b000, 3'b100, {3'b110, 3'b000, 3'b000});
    run_txn(3'b001, 3'b000, 2'b01, 3'd0, 3'b000, 3'b000, 3'b000, '0);
    // Round-robin under continuous requests
    model_reset();
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 3; i++) run_txn(3'b111, 3'b111, 2'b01, 3'd3, 3'b000, 0, 0, '0);
    for (int i = 0; i < 4; i++) run_txn(3'b101, 3'b101, 2'b10, 3'd4, 3'b000, 0, 0, '0);
    bus_if.req = '0;
    // Own dirty bit masked, then double-dirty sets sticky err
    run_txn(3'b001, 3'b000, 2'b01, 3'd2, 3'b000, 3'b000, 3'b001, {3'b111, 3'b101, 3'b100});
    run_txn(3'b001, 3'b000, 2'b01, 3'd2, 3'b000, 3'b000, 3'b110, {3'b111, 3'b011, 3'b100});
    run_txn(3'b001, 3'b000, 2'b11, 3'd2, 3'b000, 3'b011, 3'b000, '0);

    // Reset during WAIT of a P2 write-back
    bus_if.req      = 3'b100;
    bus_if.req_cmd  = {2'b00, 2'b01, 2'b01};
    bus_if.req_addr = {3'd6, 3'd0, 3'd0};
    bus_if.req_data = {3'b101, 3'b000, 3'b000};
    @(negedge clock);
    check("rstmid_gnt", bus_if.gnt, 3'b100);
    @(negedge clock);
    clear = 1'b0;
    #1;
    check("rstmid_gnt0", bus_if.gnt, 0);
    check("rstmid_bus_valid", bus_if.bus_valid, 0);
    check("rstmid_busy", bus_if.busy, 0);
    check("rstmid_err", bus_if.err, 0);
    model_reset();
    check_stats("rstmid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rstmid_no_resp", bus_if.resp_valid, 0);
    end
    clear_inputs();
    clear = 1'b1;
    @(negedge clock);
    run_txn(3'b001, 3'b000, 2'b01, 3'd6, 3'b000, 3'b000, 3'b000, '0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       dt = '0;
        1:       dt = NPROC'(1) << $urandom_range(0, NPROC - 1);
        2:       dt = NPROC'($urandom);
        default: dt = '0;
      endcase
      run_txn(NPROC'($urandom_range(1, 7)), NPROC'($urandom), 2'($urandom),
              ADDR_W'($urandom), DATA_W'($urandom), NPROC'($urandom), dt,
              (DATA_W*NPROC)'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
